multicycle_stack_controller: RTL
================================

MULTICYCLE_STACK_CONTROLLER -- requirements
Module: multicycle_stack_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- IR_W, 16, instruction width
- OPC_W, 5, opcode field width, taken from ir[IR_W-1 -: OPC_W]
- SP_W, 8, stack-pointer width; stack depth is 2^SP_W
- WAIT_W, 4, memory-wait timeout counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, single clock; all state changes on posedge
- reset, in, 1, asynchronous, active-high
- ir, in, IR_W, instruction register contents
- sp, in, SP_W, current stack pointer from the datapath
- mem_ready, in, 1, memory completes the current access this cycle
- ld_ir / ld_reg / ld_pc / ld_sp, out, 1 each, single-cycle load strobes
- mem_read / mem_write, out, 1 each, memory request; held until mem_ready
- instr_fetch, out, 1, 1 = address is PC; 0 = stack address
- addr_sel, out, 1, 0 = sp; 1 = sp+1
- din_sel, out, 1, 0 = register; 1 = PC+1
- sp_up, out, 1, 1 = sp+1; 0 = sp-1; valid with ld_sp
- reg_sel, out, 1, 0 = ALU result; 1 = memory data
- alu_op, out, 2, 00 ADD, 01 SUB, 10 AND, 11 OR
- pc_sel, out, 2, 00 = PC+1; 01 = PC+1+label; 10 = memory data
- halted, out, 1, sticky halt indication
- fault, out, 1, sticky fault indication
- fault_code, out, 2, fault cause; valid while fault=1
- state_o, out, 3, current state encoding

Function
REQ-003 The opcodes SHALL be:
- 00000 PUSH: M[sp] <= reg; sp-1
- 00001 POP: reg <= M[sp+1]; sp+1
- 00010–00101 ALU ADD/SUB/AND/OR: reg <= reg op M[sp+1]; sp+1
- 00110 CALL: M[sp] <= PC+1; sp-1; PC <= PC+1+label
- 00111 RET: PC <= M[sp+1]; sp+1
- 01000 BR: PC <= PC+1+label
- 01001 NOP
- 11111 HALT
- any other opcode is illegal
REQ-004 The states SHALL be FETCH=000, EXEC=001, MEM=010, WB=011, HALT=100 and FAULT=101.
REQ-005 FETCH SHALL assert mem_read and instr_fetch, then pulse ld_ir and go to EXEC in the cycle mem_ready=1.
REQ-006 EXEC SHALL decode the opcode and go to:
- FAULT for an illegal opcode, an overflow or an underflow
- HALT for HALT
- MEM for PUSH, POP, ALU, CALL and RET
- WB for BR and NOP
REQ-007 In MEM, mem_write SHALL be asserted for PUSH and CALL, and mem_read for the other memory opcodes.
REQ-008 MEM SHALL hold its request and all select outputs stable until mem_ready=1, then go to WB.
REQ-009 WB SHALL assert the following for exactly one cycle, then return to FETCH:
- ld_pc
- ld_sp for stack opcodes
- ld_reg for POP and ALU
- pc_sel and sp_up per REQ-003
REQ-010 All outputs SHALL be combinational from the state and the latched opcode.
REQ-011 Outside their active states, ld_* strobes SHALL be 0, mem_read and mem_write SHALL be 0, and select outputs SHALL be 0.
REQ-012 The opcode SHALL be captured at the ld_ir cycle and held internally until the next FETCH; ir changes outside FETCH SHALL be ignored.
REQ-013 A PUSH or CALL with sp==0 SHALL fault with overflow, code 01, and issue no memory write and no ld_sp.
REQ-014 A POP, ALU or RET with sp=={SP_W{1}} SHALL fault with underflow, code 10, and issue no memory access.
REQ-015 An illegal opcode SHALL fault with code 00.
REQ-016 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-017 If the wait counter reaches 2^WAIT_W-1 with mem_ready still 0, the block SHALL enter FAULT with code 11 and deassert the request.
REQ-018 If mem_ready=1 in the same cycle the counter reaches its maximum, the access SHALL complete and no fault SHALL be raised.
REQ-019 HALT and FAULT SHALL be terminal: halted or fault held at 1, all strobes held at 0, and exit only by reset.
REQ-020 Latency with mem_ready tied to 1 SHALL be 3 cycles for BR and NOP, and 4 cycles for memory opcodes.

Reset
REQ-021 While reset=1 the block SHALL hold:
- state FETCH
- all strobes, mem_read and mem_write at 0
- halted, fault, fault_code and the wait counter at 0
REQ-022 Reset asserted mid-access SHALL abort the access immediately, with no ld_* pulse.
REQ-023 After reset deasserts, the first rising clock edge SHALL begin a new FETCH.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- mem_ready=1, PUSH, sp=5 -> state trace 000,001,010,011; mem_write in MEM with addr_sel=0, din_sel=0; WB ld_sp=1, sp_up=0, ld_pc=1, pc_sel=00
- CALL, sp=3, mem_ready low 3 cycles in MEM -> mem_write held 4 cycles; WB pc_sel=01, ld_sp=1, sp_up=0
- POP with sp=8'hFF -> FAULT, fault_code=10, no mem_read
- PUSH with sp=0 -> FAULT, fault_code=01, no mem_write
- mem_ready held 0 in FETCH, WAIT_W=4 -> FAULT, fault_code=11 after 15 wait cycles
- mem_ready=1 in the 15th wait cycle -> no fault
- opcode 10101 -> FAULT, code 00
- HALT -> halted=1, frozen
- reset mid-MEM -> state 000, all strobes 0 within the same cycle

Source files
------------

// File: rtl/multicycle_stack_controller.sv
// Multicycle control FSM for a stack machine: fetch, decode, one stack access, writeback.
// Stack bounds and memory wait time are guarded by a sticky fault with a cause code.
module multicycle_stack_controller #(
  parameter int IR_W   = 16,
  parameter int OPC_W  = 5,
  parameter int SP_W   = 8,
  parameter int WAIT_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [IR_W-1:0] ir,
  input  logic [SP_W-1:0] sp,
  input  logic            mem_ready,
  output logic            ld_ir,
  output logic            ld_reg,
  output logic            ld_pc,
  output logic            ld_sp,
  output logic            mem_read,
  output logic            mem_write,
  output logic            instr_fetch,
  output logic            addr_sel,
  output logic            din_sel,
  output logic            sp_up,
  output logic            reg_sel,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_sel,
  output logic            halted,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_FETCH = 3'b000,
    S_EXEC  = 3'b001,
    S_MEM   = 3'b010,
    S_WB    = 3'b011,
    S_HALT  = 3'b100,
    S_FAULT = 3'b101
  } state_t;

  localparam logic [OPC_W-1:0] OP_PUSH = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_POP  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_CALL = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_BR   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_HALT = '1;

  localparam logic [1:0] FC_ILLEGAL  = 2'b00;
  localparam logic [1:0] FC_OVERFLOW = 2'b01;
  localparam logic [1:0] FC_UNDERFLW = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  // A wait cycle seen at this count is the one that drives the counter to its maximum.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((1 << WAIT_W) - 2);

  state_t            state, state_next;
  logic [1:0]        code, code_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [OPC_W-1:0]  opc;

  logic is_push, is_pop, is_alu, is_call, is_ret, is_br, is_halt, is_illegal;
  logic is_write, is_read, is_stack, timeout;
  logic unused_ir;

  assign unused_ir  = ^ir[IR_W-OPC_W-1:0];

  assign is_push    = (opc == OP_PUSH);
  assign is_pop     = (opc == OP_POP);
  assign is_alu     = (opc >= OP_ADD) && (opc <= OP_OR);
  assign is_call    = (opc == OP_CALL);
  assign is_ret     = (opc == OP_RET);
  assign is_br      = (opc == OP_BR);
  assign is_halt    = (opc == OP_HALT);
  assign is_illegal = (opc > OP_NOP) && !is_halt;
  assign is_write   = is_push | is_call;
  assign is_read    = is_pop | is_alu | is_ret;
  assign is_stack   = is_write | is_read;
  assign timeout    = !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    code_next  = code;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_EXEC;
        end else if (timeout) begin
          state_next = S_FAULT;
          code_next  = FC_TIMEOUT;
        end
      end
      S_EXEC: begin
        if (is_illegal) begin
          state_next = S_FAULT;
          code_next  = FC_ILLEGAL;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else if (is_write && (sp == '0)) begin
          state_next = S_FAULT;
          code_next  = FC_OVERFLOW;
        end else if (is_read && (sp == '1)) begin
          state_next = S_FAULT;
          code_next  = FC_UNDERFLW;
        end else if (is_stack) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_next = S_WB;
        end else if (timeout) begin
          state_next = S_FAULT;
          code_next  = FC_TIMEOUT;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  always_comb begin
    wait_next = wait_cnt;
    if ((state_next == S_FETCH || state_next == S_MEM) && (state_next != state)) begin
      wait_next = '0;
    end else if ((state == S_FETCH || state == S_MEM) && !mem_ready) begin
      wait_next = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      code     <= '0;
      wait_cnt <= '0;
      opc      <= '0;
    end else begin
      state    <= state_next;
      code     <= code_next;
      wait_cnt <= wait_next;
      if (state == S_FETCH && mem_ready) begin
        opc <= ir[IR_W-1 -: OPC_W];
      end
    end
  end

  // Reset gates the outputs directly so an aborted access drops in the same cycle.
  always_comb begin
    ld_ir       = 1'b0;
    ld_reg      = 1'b0;
    ld_pc       = 1'b0;
    ld_sp       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    instr_fetch = 1'b0;
    addr_sel    = 1'b0;
    din_sel     = 1'b0;
    sp_up       = 1'b0;
    reg_sel     = 1'b0;
    alu_op      = 2'b00;
    pc_sel      = 2'b00;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read    = 1'b1;
          instr_fetch = 1'b1;
          ld_ir       = mem_ready;
        end
        S_MEM: begin
          mem_write = is_write;
          mem_read  = is_read;
          addr_sel  = is_read;
          din_sel   = is_call;
        end
        S_WB: begin
          ld_pc   = 1'b1;
          ld_sp   = is_stack;
          sp_up   = is_read;
          ld_reg  = is_pop | is_alu;
          reg_sel = is_pop;
          if (is_alu) alu_op = opc[1:0] - 2'd2;
          if (is_call || is_br) pc_sel = 2'b01;
          else if (is_ret)      pc_sel = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign halted     = (state == S_HALT);
  assign fault      = (state == S_FAULT);
  assign fault_code = code;
  assign state_o    = state;

endmodule
